// File: rtl/ifetch_pkg.sv
// Shared widths, constants and FSM encoding for the MIPS instruction-fetch stage.
package ifetch_pkg;

  localparam int PC_WIDTH = 32;
  localparam int IWIDTH   = 32;

  localparam logic [IWIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return addr & ~PC_WIDTH'(3);
  endfunction

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface ifetch_if;
  import ifetch_pkg::*;

  logic                if_o_im_ce;
  logic [PC_WIDTH-1:0] if_o_im_addr;
  logic [IWIDTH-1:0]   if_i_im_instr;
  logic                if_i_im_ce;

  modport master (
    output if_o_im_ce,
    output if_o_im_addr,
    input  if_i_im_instr,
    input  if_i_im_ce
  );

  modport slave (
    input  if_o_im_ce,
    input  if_o_im_addr,
    output if_i_im_instr,
    output if_i_im_ce
  );

endinterface

// File: rtl/ifetch_skid.sv
// One-entry pc+instruction holding buffer that catches the memory return during a stall.
module ifetch_skid
  import ifetch_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                unload_i,
  input  logic                clear_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [IWIDTH-1:0]   instr_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [IWIDTH-1:0]   instr_o
);

  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [IWIDTH-1:0]   instr_q;

  // Clear beats load so a redirect or flush in the stalled cycle drops the return.
  always_comb begin
    valid_d = valid_q;
    if (clear_i)       valid_d = 1'b0;
    else if (load_i)   valid_d = 1'b1;
    else if (unload_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the fetch PC, issues reads to a 1-cycle memory and feeds the IF/ID register.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                if_clk,
  input  logic                if_rst,
  input  logic                if_i_stall,
  input  logic                if_i_flush,
  input  logic                if_i_redirect,
  input  logic [PC_WIDTH-1:0] if_i_target,
  ifetch_if.master            im,
  output logic [PC_WIDTH-1:0] if_o_pc,
  output logic [PC_WIDTH-1:0] if_o_pc_plus4,
  output logic [IWIDTH-1:0]   if_o_instr,
  output logic                if_o_valid
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                infl_valid_q, infl_valid_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;

  logic                ifid_valid_q, ifid_valid_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [PC_WIDTH-1:0] ifid_p4_q, ifid_p4_d;
  logic [IWIDTH-1:0]   ifid_instr_q, ifid_instr_d;

  logic                issue, arrival;
  logic                skid_load, skid_unload, skid_clear;
  logic                skid_valid;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [IWIDTH-1:0]   skid_instr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign issue   = (state_q == RUN) & ~if_i_stall & ~if_i_redirect;
  assign arrival = infl_valid_q & im.if_i_im_ce;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    infl_valid_d = issue;
    infl_pc_d    = infl_pc_q;
    if (if_i_redirect)  fetch_pc_d = word_align(if_i_target);
    else if (issue)     fetch_pc_d = pc_inc(fetch_pc_q);
    if (issue)          infl_pc_d  = fetch_pc_q;
  end

  assign skid_clear  = if_i_flush | if_i_redirect;
  assign skid_load   = ~if_i_flush & if_i_stall & arrival;
  assign skid_unload = ~if_i_flush & ~if_i_stall & skid_valid;

  // IF/ID priority: flush, stall hold, skid drain, fresh arrival, bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_p4_d    = ifid_p4_q;
    ifid_instr_d = ifid_instr_q;
    if (if_i_flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (if_i_stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (skid_valid) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = skid_pc;
      ifid_p4_d    = pc_inc(skid_pc);
      ifid_instr_d = skid_instr;
    end else if (arrival) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = infl_pc_q;
      ifid_p4_d    = pc_inc(infl_pc_q);
      ifid_instr_d = im.if_i_im_instr;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge if_clk or posedge if_rst) begin
    if (if_rst) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      infl_valid_q <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_p4_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      infl_valid_q <= infl_valid_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_p4_q    <= ifid_p4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  always_ff @(posedge if_clk) begin
    infl_pc_q <= infl_pc_d;
  end

  ifetch_skid u_skid (
    .clk_i    (if_clk),
    .rst_i    (if_rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .pc_i     (infl_pc_q),
    .instr_i  (im.if_i_im_instr),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  assign im.if_o_im_ce   = issue;
  assign im.if_o_im_addr = fetch_pc_q;

  assign if_o_valid    = ifid_valid_q;
  assign if_o_pc       = ifid_pc_q;
  assign if_o_pc_plus4 = ifid_p4_q;
  assign if_o_instr    = ifid_instr_q;

endmodule
